// File: rtl/multiword_alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : multiword_alu_seq_if
//  Description : Bundle of the request/response signals and the external
//                adder-slice signals for multiword_alu_seq.
//                Ports (W = N*K):
//                  start, op, a[W], b[W], c_in   request side
//                  busy, done, result[W], c_out  response side
//                  dp_a[N], dp_b[N], dp_cin      slice operands to the adder
//                  dp_sum[N], dp_cout            slice result from the adder
//                slave  : the sequencer (multiword_alu_seq)
//                master : its environment (requester plus adder slice)
//  Revision    : 1.0  initial release
// ============================================================================
interface multiword_alu_seq_if #(
    parameter int N = 4,
    parameter int K = 4
);
    localparam int W = N * K;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic [N-1:0] dp_a;
    logic [N-1:0] dp_b;
    logic         dp_cin;
    logic [N-1:0] dp_sum;
    logic         dp_cout;

    modport slave (
        input  start, op, a, b, c_in, dp_sum, dp_cout,
        output busy, done, result, c_out, dp_a, dp_b, dp_cin
    );

    modport master (
        output start, op, a, b, c_in, dp_sum, dp_cout,
        input  busy, done, result, c_out, dp_a, dp_b, dp_cin
    );
endinterface
`default_nettype wire

// File: rtl/multiword_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : multiword_alu_seq
//  Description : Multi-cycle W = N*K bit ADD / AND controller that time-shares
//                one external combinational N-bit adder slice, least
//                significant slice first, with the carry held in a register
//                between slices.
//                Ports:
//                  clk    rising-edge clock
//                  rst_n  asynchronous active-low reset
//                  bus    multiword_alu_seq_if.slave (request, response and
//                         external adder-slice signals)
//  Revision    : 1.0  initial release
// ============================================================================
module multiword_alu_seq #(
    parameter int N = 4,
    parameter int K = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    multiword_alu_seq_if.slave     bus
);
    localparam int W     = N * K;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(K - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_op;
    logic             r_carry;
    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_result;
    logic             r_c_out;

    logic             w_run;
    logic [N-1:0]     w_a_slice;
    logic [N-1:0]     w_b_slice;
    logic [N-1:0]     w_slice_res;
    logic             w_carry_next;
    logic [W-1:0]     w_acc_next;

    assign w_run     = (r_state == c_RUN);
    assign w_a_slice = r_a[r_idx*N +: N];
    assign w_b_slice = r_b[r_idx*N +: N];

    // AND bypasses the adder entirely; the slice is still driven out but its
    // sum/carry are discarded and the carry chain is forced to 0.
    assign w_slice_res  = r_op ? (w_a_slice & w_b_slice) : bus.dp_sum;
    assign w_carry_next = r_op ? 1'b0 : bus.dp_cout;

    // Accumulator with the current slice replaced; also feeds the final result
    // on the last slice so result only ever changes on the RUN->DONE edge.
    always_comb begin
        w_acc_next                  = r_acc;
        w_acc_next[r_idx*N +: N]    = w_slice_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_carry  <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
            r_c_out  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_op    <= bus.op;
                        r_carry <= bus.op ? 1'b0 : bus.c_in;
                        r_idx   <= '0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_carry_next;
                    if (r_idx == c_LAST_IDX) begin
                        r_result <= w_acc_next;
                        r_c_out  <= w_carry_next;
                        r_state  <= c_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (r_state == c_RUN) || (r_state == c_DONE);
    assign bus.done   = (r_state == c_DONE);
    assign bus.result = r_result;
    assign bus.c_out  = r_c_out;

    // The adder is only addressed while a slice is being processed.
    assign bus.dp_a   = w_run ? w_a_slice : '0;
    assign bus.dp_b   = w_run ? w_b_slice : '0;
    assign bus.dp_cin = w_run ? r_carry   : 1'b0;

endmodule
`default_nettype wire
